// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART pair (uart_tx / uart_rx) running on the
// 3.125 MHz clock at 230400 baud.
//   uart_state_e : receiver FSM state encoding
//   BIT_CYCLES   : clock cycles per bit window
//   PARITY_EVEN / PARITY_ODD : parity_type input encoding, shared with uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int BIT_CYCLES = 14;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so that idle-high lines (such as a UART rx) do not show a false
// edge when reset is released.
//   clk   : destination clock
//   rst   : asynchronous active-high reset
//   d     : asynchronous input
//   q     : synchronised output, 2 cycles behind d
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: 1 start bit, 8 data bits MSB first, 1 parity bit (even or
// odd), 1 stop bit, BIT_CYCLES clocks per bit. Produces a one-cycle
// rx_complete strobe with the byte, the received parity bit and the error
// flags, which hold until the next completed frame.
//   clk_3125      : 3.125 MHz system clock
//   reset         : asynchronous active-high reset
//   rx            : serial line, idles high
//   parity_type   : 0 = even, 1 = odd; captured at start detection
//   rx_msg        : received byte, rx_msg[7] = first data bit on the line
//   rx_parity     : parity bit as received
//   parity_error  : received parity differs from the expected parity
//   framing_error : stop bit sampled low
//   rx_complete   : one-cycle strobe, other outputs valid while high
module uart_rx #(
    parameter int BIT_CYCLES   = uart_pkg::BIT_CYCLES,
    parameter int SAMPLE_POINT = 6
) (
    input  logic       clk_3125,
    input  logic       reset,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_complete
);

    import uart_pkg::*;

    logic rx_s;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk_3125),
        .rst(reset),
        .d  (rx),
        .q  (rx_s)
    );

    uart_state_e state_q, state_d;
    logic [3:0]  cyc_cnt_q, cyc_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        ptype_q, ptype_d;
    logic [7:0]  rx_msg_q, rx_msg_d;
    logic        rx_parity_q, rx_parity_d;
    logic        parity_error_q, parity_error_d;
    logic        framing_error_q, framing_error_d;
    logic        rx_complete_q, rx_complete_d;

    // The counter is cleared on the start-detection edge t0, so when it reads
    // n the coming edge is t0 + n + 1 (mod window). Sampling at SAMPLE_POINT-1
    // therefore lands on edge t0 + 14k + SAMPLE_POINT, and the window closes
    // on edge t0 + 14k + 14.
    logic sample_now;
    logic win_end;
    logic exp_parity;

    assign sample_now = (cyc_cnt_q == 4'(SAMPLE_POINT - 1));
    assign win_end    = (cyc_cnt_q == 4'(BIT_CYCLES - 1));
    assign exp_parity = (ptype_q == PARITY_EVEN) ? ^shift_q : ~^shift_q;

    always_comb begin
        state_d         = state_q;
        cyc_cnt_d       = win_end ? 4'd0 : cyc_cnt_q + 4'd1;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        par_d           = par_q;
        ptype_d         = ptype_q;
        rx_msg_d        = rx_msg_q;
        rx_parity_d     = rx_parity_q;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        rx_complete_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_cnt_d = 4'd0;
                if (!rx_s) begin
                    ptype_d   = parity_type;
                    bit_cnt_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                // A high mid-bit sample means the low was a glitch.
                if (sample_now && rx_s) begin
                    state_d = IDLE;
                end else if (win_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_now) begin
                    shift_d = {shift_q[6:0], rx_s};
                end
                if (win_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sample_now) begin
                    par_d = rx_s;
                end
                if (win_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Finish at the stop-bit sample rather than the window end,
                // leaving slack for back-to-back frames.
                if (sample_now) begin
                    rx_msg_d        = shift_q;
                    rx_parity_d     = par_q;
                    parity_error_d  = (par_q != exp_parity);
                    framing_error_d = ~rx_s;
                    rx_complete_d   = 1'b1;
                    state_d         = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must return high before a new start.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cyc_cnt_q       <= 4'd0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'd0;
            par_q           <= 1'b0;
            ptype_q         <= 1'b0;
            rx_msg_q        <= 8'd0;
            rx_parity_q     <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            rx_complete_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cyc_cnt_q       <= cyc_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_q           <= par_d;
            ptype_q         <= ptype_d;
            rx_msg_q        <= rx_msg_d;
            rx_parity_q     <= rx_parity_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            rx_complete_q   <= rx_complete_d;
        end
    end

    assign rx_msg        = rx_msg_q;
    assign rx_parity     = rx_parity_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign rx_complete   = rx_complete_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk_3125 = 1'b0;
    logic       reset;
    logic       rx;
    logic       parity_type;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       parity_error;
    logic       framing_error;
    logic       rx_complete;

    uart_rx dut (
        .clk_3125     (clk_3125),
        .reset        (reset),
        .rx           (rx),
        .parity_type  (parity_type),
        .rx_msg       (rx_msg),
        .rx_parity    (rx_parity),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .rx_complete  (rx_complete)
    );

    always #160 clk_3125 = ~clk_3125;

    int total = 0;
    int bad   = 0;
    int pcnt  = 0;
    int strobes = 0;
    int strobe_p = 0;
    int start_p  = 0;
    logic [7:0] msg_log [0:31];
    logic       pe_log  [0:31];
    logic       fe_log  [0:31];

    always @(posedge clk_3125) pcnt <= pcnt + 1;

    // Strobe monitor: logs every completed frame, one line per frame.
    always @(negedge clk_3125) begin
        if (rx_complete) begin
            if (strobes < 32) begin
                msg_log[strobes] <= rx_msg;
                pe_log[strobes]  <= parity_error;
                fe_log[strobes]  <= framing_error;
            end
            strobe_p <= pcnt;
            strobes  <= strobes + 1;
            $display("frame %0d: rx_msg=0x%02h rx_parity=%0b parity_error=%0b framing_error=%0b",
                     strobes, rx_msg, rx_parity, parity_error, framing_error);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-bang one frame; each bit is held for 14 cycles, driven on negedges.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {1'b0, d, p, s};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk_3125);
            rx = bits[i];
            if (i == 10) start_p = pcnt;
            repeat (13) @(negedge clk_3125);
        end
        #1;
    endtask

    initial begin
        logic [7:0] c3;
        reset = 1'b1;
        rx = 1'b1;
        parity_type = 1'b0;
        repeat (3) @(negedge clk_3125);
        #1;
        chk("reset_rx_msg", 32'(rx_msg), 32'h00);
        chk("reset_rx_parity", 32'(rx_parity), 32'h0);
        chk("reset_parity_error", 32'(parity_error), 32'h0);
        chk("reset_framing_error", 32'(framing_error), 32'h0);
        chk("reset_rx_complete", 32'(rx_complete), 32'h0);
        @(negedge clk_3125);
        reset = 1'b0;
        repeat (5) @(negedge clk_3125);

        // 0xA5 even parity (4 ones -> parity bit 0)
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_strobes", 32'(strobes), 32'd1);
        chk("a5_msg", 32'(msg_log[0]), 32'hA5);
        chk("a5_rx_parity", 32'(rx_parity), 32'h0);
        chk("a5_parity_error", 32'(pe_log[0]), 32'h0);
        chk("a5_framing_error", 32'(fe_log[0]), 32'h0);
        chk("a5_latency", 32'(strobe_p - start_p), 32'd149);

        // 0x3C odd parity: expected bit 1, send 0 then 1
        parity_type = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("3c_bad_strobes", 32'(strobes), 32'd2);
        chk("3c_bad_msg", 32'(msg_log[1]), 32'h3C);
        chk("3c_bad_parity_error", 32'(pe_log[1]), 32'h1);
        chk("3c_bad_rx_parity", 32'(rx_parity), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b1);
        chk("3c_ok_strobes", 32'(strobes), 32'd3);
        chk("3c_ok_parity_error", 32'(pe_log[2]), 32'h0);
        chk("3c_ok_rx_parity", 32'(rx_parity), 32'h1);

        // Glitch: 3 cycles low while idle
        parity_type = 1'b0;
        @(negedge clk_3125);
        rx = 1'b0;
        repeat (3) @(negedge clk_3125);
        rx = 1'b1;
        repeat (20) @(negedge clk_3125);
        #1;
        chk("glitch_no_strobe", 32'(strobes), 32'd3);
        send_frame(8'h55, 1'b0, 1'b1);
        chk("55_strobes", 32'(strobes), 32'd4);
        chk("55_msg", 32'(msg_log[3]), 32'h55);
        chk("55_parity_error", 32'(pe_log[3]), 32'h0);

        // Framing error then break (line left low)
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (40) @(negedge clk_3125);
        #1;
        chk("81_strobes", 32'(strobes), 32'd5);
        chk("81_msg", 32'(msg_log[4]), 32'h81);
        chk("81_framing_error", 32'(fe_log[4]), 32'h1);
        chk("81_parity_error", 32'(pe_log[4]), 32'h0);
        @(negedge clk_3125);
        rx = 1'b1;
        repeat (20) @(negedge clk_3125);
        #1;
        chk("break_no_extra_strobe", 32'(strobes), 32'd5);

        // Back-to-back frames
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (5) @(negedge clk_3125);
        #1;
        chk("b2b_strobes", 32'(strobes), 32'd8);
        chk("b2b_msg0", 32'(msg_log[5]), 32'h00);
        chk("b2b_msg1", 32'(msg_log[6]), 32'hFF);
        chk("b2b_msg2", 32'(msg_log[7]), 32'h5A);
        chk("b2b_fe0", 32'(fe_log[5]), 32'h0);
        chk("b2b_errs", 32'({pe_log[5], pe_log[6], pe_log[7], fe_log[6], fe_log[7]}), 32'h0);

        // Reset during data bit 3 of 0xC3
        c3 = 8'hC3;
        @(negedge clk_3125);
        rx = 1'b0;
        repeat (13) @(negedge clk_3125);
        for (int i = 7; i >= 4; i--) begin
            @(negedge clk_3125);
            rx = c3[i];
            repeat (13) @(negedge clk_3125);
        end
        @(negedge clk_3125);
        rx = c3[3];
        repeat (7) @(negedge clk_3125);
        reset = 1'b1;
        #1;
        chk("midreset_rx_msg", 32'(rx_msg), 32'h00);
        chk("midreset_rx_parity", 32'(rx_parity), 32'h0);
        chk("midreset_errors", 32'({parity_error, framing_error}), 32'h0);
        chk("midreset_rx_complete", 32'(rx_complete), 32'h0);
        rx = 1'b1;
        repeat (5) @(negedge clk_3125);
        reset = 1'b0;
        repeat (150) @(negedge clk_3125);
        #1;
        chk("midreset_no_strobe", 32'(strobes), 32'd8);

        // 0x3E even parity (5 ones -> parity bit 1)
        send_frame(8'h3E, 1'b1, 1'b1);
        chk("3e_strobes", 32'(strobes), 32'd9);
        chk("3e_msg", 32'(msg_log[8]), 32'h3E);
        chk("3e_rx_parity", 32'(rx_parity), 32'h1);
        chk("3e_parity_error", 32'(pe_log[8]), 32'h0);
        chk("3e_framing_error", 32'(fe_log[8]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
